elastic_pipe_reg: RTL and testbench

Parametrised, elastic pipeline register chain for the DSP datapath. It carries a WIDTH-bit sample through DEPTH register stages with valid/ready flow control, bubble collapsing, a global clock-enable, a synchronous flush and an occupancy count. It is the standard inter-stage register between pre-adder, multiplier and accumulator slices, and replaces hand-instantiated single enable flops wherever backpressure is needed.

---
 rtl/elastic_pipe_reg_pkg.sv | 7 +
 rtl/elastic_pipe_stage.sv | 38 +++
 rtl/elastic_pipe_reg.sv | 87 ++++++++
 tb/tb_elastic_pipe_reg.sv | 316 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/elastic_pipe_reg_pkg.sv
// Shared DSP datapath constants for the elastic pipeline register.
// Imported by the stage and the register chain.
package elastic_pipe_reg_pkg;

   localparam int unsigned DSP_DATA_W = 18;

endpackage

// File: rtl/elastic_pipe_stage.sv
// One valid/data register pair of the elastic chain.
// Data only loads with a valid source sample, so bubbles do not toggle it.
module elastic_pipe_stage
   import elastic_pipe_reg_pkg::*;
#(
   parameter int unsigned WIDTH = DSP_DATA_W
) (
   input  logic             clk,
   input  logic             s_rst,
   input  logic             i_flush,
   input  logic             i_ld,
   input  logic             i_src_v,
   input  logic [WIDTH-1:0] i_src_d,
   output logic             o_v,
   output logic [WIDTH-1:0] o_d
);

   logic             r_v;
   logic [WIDTH-1:0] r_d;

   always_ff @(posedge clk) begin
      if (s_rst) begin
         r_v <= 1'b0;
         r_d <= '0;
      end else if (i_flush) begin
         r_v <= 1'b0;
      end else if (i_ld) begin
         r_v <= i_src_v;
         if (i_src_v) begin
            r_d <= i_src_d;
         end
      end
   end

   assign o_v = r_v;
   assign o_d = r_d;

endmodule

// File: rtl/elastic_pipe_reg.sv
// Elastic valid/ready register chain of DEPTH stages with bubble
// collapsing, clock enable, flush and occupancy; DEPTH=0 is a wire.
module elastic_pipe_reg
   import elastic_pipe_reg_pkg::*;
#(
   parameter  int unsigned WIDTH = DSP_DATA_W,
   parameter  int unsigned DEPTH = 2,
   localparam int unsigned OCC_W = (DEPTH == 0) ? 1 : $clog2(DEPTH + 1)
) (
   input  logic             clk,
   input  logic             s_rst,
   input  logic             ce,
   input  logic             flush,
   input  logic             in_valid,
   input  logic [WIDTH-1:0] in_data,
   output logic             in_ready,
   output logic             out_valid,
   output logic [WIDTH-1:0] out_data,
   input  logic             out_ready,
   output logic [OCC_W-1:0] occupancy
);

   if (DEPTH == 0) begin : g_pass
      logic w_unused;

      assign w_unused  = ^{clk, s_rst, flush};
      assign in_ready  = out_ready & ce;
      assign out_valid = in_valid & ce;
      assign out_data  = in_data;
      assign occupancy = '0;
   end else begin : g_chain
      logic [DEPTH:0]   w_ld;
      logic [DEPTH-1:0] w_v;
      logic [DEPTH-1:0] w_sv;
      logic [WIDTH-1:0] w_d  [DEPTH];
      logic [WIDTH-1:0] w_sd [DEPTH];
      logic [OCC_W-1:0] w_occ;

      // Ready ripples from the output back; any hole lets upstream move.
      always_comb begin
         w_ld        = '0;
         w_ld[DEPTH] = out_ready;
         for (int i = int'(DEPTH) - 1; i >= 0; i--) begin
            w_ld[i] = ce & (~w_v[i] | w_ld[i+1]);
         end
      end

      always_comb begin
         w_sv    = '0;
         w_sd    = '{default: '0};
         w_sv[0] = in_valid;
         w_sd[0] = in_data;
         for (int i = 1; i < int'(DEPTH); i++) begin
            w_sv[i] = w_v[i-1];
            w_sd[i] = w_d[i-1];
         end
      end

      always_comb begin
         w_occ = '0;
         for (int i = 0; i < int'(DEPTH); i++) begin
            w_occ = w_occ + OCC_W'(w_v[i]);
         end
      end

      for (genvar g = 0; g < DEPTH; g++) begin : g_stage
         elastic_pipe_stage #(
            .WIDTH (WIDTH)
         ) u_stage (
            .clk     (clk),
            .s_rst   (s_rst),
            .i_flush (flush),
            .i_ld    (w_ld[g]),
            .i_src_v (w_sv[g]),
            .i_src_d (w_sd[g]),
            .o_v     (w_v[g]),
            .o_d     (w_d[g])
         );
      end

      assign in_ready  = w_ld[0];
      assign out_valid = w_v[DEPTH-1];
      assign out_data  = w_d[DEPTH-1];
      assign occupancy = w_occ;
   end

endmodule

// File: tb/tb_elastic_pipe_reg.sv
// Bench for elastic_pipe_reg: DEPTH 0/2/3/4 instances on shared inputs,
// hand sequences, a DEPTH=0 vector table and a slot-level random model.
module tb_elastic_pipe_reg;

   localparam int W = 18;

   logic         clk = 1'b0;
   logic         s_rst = 1'b1;
   logic         ce = 1'b1;
   logic         flush = 1'b0;
   logic         in_valid = 1'b0;
   logic [W-1:0] in_data = '0;
   logic         out_ready = 1'b1;

   logic         rdy0, ov0, rdy2, ov2, rdy3, ov3, rdy4, ov4;
   logic [W-1:0] od0, od2, od3, od4;
   logic [0:0]   occ0;
   logic [1:0]   occ2, occ3;
   logic [2:0]   occ4;

   always #5 clk = ~clk;

   elastic_pipe_reg #(.WIDTH(W), .DEPTH(0)) u_d0 (
      .clk(clk), .s_rst(s_rst), .ce(ce), .flush(flush),
      .in_valid(in_valid), .in_data(in_data), .in_ready(rdy0),
      .out_valid(ov0), .out_data(od0), .out_ready(out_ready),
      .occupancy(occ0));

   elastic_pipe_reg #(.WIDTH(W), .DEPTH(2)) u_d2 (
      .clk(clk), .s_rst(s_rst), .ce(ce), .flush(flush),
      .in_valid(in_valid), .in_data(in_data), .in_ready(rdy2),
      .out_valid(ov2), .out_data(od2), .out_ready(out_ready),
      .occupancy(occ2));

   elastic_pipe_reg #(.WIDTH(W), .DEPTH(3)) u_d3 (
      .clk(clk), .s_rst(s_rst), .ce(ce), .flush(flush),
      .in_valid(in_valid), .in_data(in_data), .in_ready(rdy3),
      .out_valid(ov3), .out_data(od3), .out_ready(out_ready),
      .occupancy(occ3));

   elastic_pipe_reg #(.WIDTH(W), .DEPTH(4)) u_d4 (
      .clk(clk), .s_rst(s_rst), .ce(ce), .flush(flush),
      .in_valid(in_valid), .in_data(in_data), .in_ready(rdy4),
      .out_valid(ov4), .out_data(od4), .out_ready(out_ready),
      .occupancy(occ4));

   int           sel = 3;
   logic         t_rdy, t_ov;
   logic [W-1:0] t_od;
   logic [3:0]   t_occ;

   always_comb begin
      t_rdy = rdy3;
      t_ov  = ov3;
      t_od  = od3;
      t_occ = {2'b0, occ3};
      case (sel)
         0: begin t_rdy = rdy0; t_ov = ov0; t_od = od0; t_occ = {3'b0, occ0}; end
         2: begin t_rdy = rdy2; t_ov = ov2; t_od = od2; t_occ = {2'b0, occ2}; end
         4: begin t_rdy = rdy4; t_ov = ov4; t_od = od4; t_occ = {1'b0, occ4}; end
         default: ;
      endcase
   end

   int n_chk = 0;
   int n_fail = 0;

   task automatic chk(input string nm, input logic [31:0] act,
                      input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)",
                  nm, act, exp, $time);
      end
   endtask

   // Reference: slots fill toward the output; everything at or below the
   // highest hole (or the whole chain when the output drains) moves up one.
   logic         mv [8];
   logic [W-1:0] mdat [8];

   function automatic int m_cnt();
      int c = 0;
      for (int i = 0; i < sel; i++) c += int'(mv[i]);
      return c;
   endfunction

   task automatic m_check();
      int c;
      if (sel == 0) begin
         chk("m_ready", t_rdy, out_ready & ce);
         chk("m_valid", t_ov, in_valid & ce);
         chk("m_data", t_od, in_data);
         chk("m_occ", t_occ, 0);
      end else begin
         c = m_cnt();
         chk("m_ready", t_rdy, ce && (c < sel || out_ready));
         chk("m_valid", t_ov, mv[sel-1]);
         chk("m_data", t_od, mdat[sel-1]);
         chk("m_occ", t_occ, c);
      end
   endtask

   task automatic m_step();
      int top;
      if (s_rst) begin
         for (int i = 0; i < 8; i++) begin
            mv[i] = 1'b0;
            mdat[i] = '0;
         end
      end else if (sel == 0) begin
      end else if (flush) begin
         for (int i = 0; i < 8; i++) mv[i] = 1'b0;
      end else if (ce) begin
         top = -1;
         if (out_ready) top = sel - 1;
         else for (int i = 0; i < sel; i++) if (!mv[i]) top = i;
         for (int i = top; i >= 1; i--) begin
            mv[i] = mv[i-1];
            if (mv[i-1]) mdat[i] = mdat[i-1];
         end
         if (top >= 0) begin
            mv[0] = in_valid;
            if (in_valid) mdat[0] = in_data;
         end
      end
   endtask

   task automatic drive(input logic r, input logic c, input logic f,
                        input logic v, input logic [W-1:0] d,
                        input logic o);
      s_rst = r; ce = c; flush = f;
      in_valid = v; in_data = d; out_ready = o;
      #2;
   endtask

   task automatic tick(input bit check = 1'b1);
      if (check) m_check();
      m_step();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset(input int d);
      sel = d;
      drive(1, 1, 0, 0, '0, 1);
      tick(1'b0);
   endtask

   typedef struct {
      logic         ce;
      logic         iv;
      logic [W-1:0] id;
      logic         ordy;
      logic         e_rdy;
      logic         e_ov;
      logic         c_od;
   } vec_t;

   vec_t tab[6];

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      tab[0] = '{1'b1, 1'b1, 18'h3FFFF, 1'b1, 1'b1, 1'b1, 1'b1};
      tab[1] = '{1'b1, 1'b0, 18'h12345, 1'b1, 1'b1, 1'b0, 1'b1};
      tab[2] = '{1'b1, 1'b1, 18'h0AAAA, 1'b0, 1'b0, 1'b1, 1'b1};
      tab[3] = '{1'b0, 1'b1, 18'h15555, 1'b1, 1'b0, 1'b0, 1'b0};
      tab[4] = '{1'b0, 1'b0, 18'h00000, 1'b0, 1'b0, 1'b0, 1'b0};
      tab[5] = '{1'b1, 1'b0, 18'h00001, 1'b0, 1'b0, 1'b0, 1'b1};
      for (int i = 0; i < 8; i++) begin
         mv[i] = 1'b0;
         mdat[i] = '0;
      end

      // Reset hold and latency, DEPTH=3
      @(posedge clk);
      #1;
      do_reset(3);
      drive(1, 1, 0, 1, 18'h1, 1);
      chk("rst_ov", t_ov, 0);
      chk("rst_od", t_od, 0);
      chk("rst_occ", t_occ, 0);
      tick();
      for (int t = 0; t < 12; t++) begin
         drive(0, 1, 0, t < 8, W'(t + 1), 1);
         if (t == 0) chk("post_rst_rdy", t_rdy, 1);
         chk("lat_ov", t_ov, t >= 3 && t < 11);
         if (t >= 3 && t < 11) chk("lat_od", t_od, t - 2);
         tick();
      end

      // Backpressure, DEPTH=3
      do_reset(3);
      drive(0, 1, 0, 1, 18'hA, 0); tick();
      drive(0, 1, 0, 1, 18'hB, 0); tick();
      drive(0, 1, 0, 1, 18'hC, 0); tick();
      drive(0, 1, 0, 0, '0, 0);
      chk("full_occ", t_occ, 3);
      chk("full_rdy", t_rdy, 0);
      chk("full_od", t_od, 18'hA);
      tick();
      drive(0, 1, 0, 1, 18'hD, 1);
      chk("pass_rdy", t_rdy, 1);
      chk("pass_od", t_od, 18'hA);
      tick();
      drive(0, 1, 0, 0, '0, 0);
      chk("swap_occ", t_occ, 3);
      chk("swap_od", t_od, 18'hB);
      tick();
      for (int k = 0; k < 4; k++) begin
         drive(0, 1, 0, 0, '0, 1);
         chk("drain_ov", t_ov, k < 3);
         if (k < 3) chk("drain_od", t_od, 18'hB + W'(k));
         tick();
      end

      // Bubble collapse, DEPTH=4
      do_reset(4);
      drive(0, 1, 0, 1, 18'h11, 0); tick();
      drive(0, 1, 0, 0, '0, 0); tick();
      drive(0, 1, 0, 1, 18'h22, 0); tick();
      drive(0, 1, 0, 0, '0, 0); tick();
      drive(0, 1, 0, 0, '0, 0); tick();
      drive(0, 1, 0, 0, '0, 0);
      chk("bub_occ", t_occ, 2);
      chk("bub_rdy", t_rdy, 1);
      chk("bub_od", t_od, 18'h11);
      tick();
      drive(0, 1, 0, 0, '0, 1); tick();
      drive(0, 1, 0, 0, '0, 0);
      chk("bub_next_ov", t_ov, 1);
      chk("bub_next_od", t_od, 18'h22);
      tick();

      // Flush with input, then ce freeze, DEPTH=2
      do_reset(2);
      drive(0, 1, 0, 1, 18'h31, 0); tick();
      drive(0, 1, 0, 1, 18'h32, 0); tick();
      drive(0, 1, 1, 1, 18'h55, 0); tick();
      for (int k = 0; k < 3; k++) begin
         drive(0, 1, 0, 0, '0, 1);
         chk("fl_ov", t_ov, 0);
         chk("fl_occ", t_occ, 0);
         tick();
      end
      drive(0, 1, 0, 1, 18'h61, 1); tick();
      drive(0, 1, 0, 1, 18'h62, 1); tick();
      for (int k = 0; k < 5; k++) begin
         drive(0, 0, 0, 1, 18'h63, 1);
         chk("ce_rdy", t_rdy, 0);
         chk("ce_ov", t_ov, 1);
         chk("ce_od", t_od, 18'h61);
         chk("ce_occ", t_occ, 2);
         tick();
      end
      for (int k = 0; k < 5; k++) begin
         drive(0, 1, 0, k < 2, 18'h63 + W'(k), 1);
         chk("res_ov", t_ov, k < 4);
         if (k < 4) chk("res_od", t_od, 18'h61 + W'(k));
         tick();
      end

      // Reset while full, DEPTH=3
      do_reset(3);
      drive(0, 1, 0, 1, 18'h71, 0); tick();
      drive(0, 1, 0, 1, 18'h72, 0); tick();
      drive(0, 1, 0, 1, 18'h73, 0); tick();
      drive(1, 1, 0, 1, 18'h74, 0); tick();
      for (int k = 0; k < 4; k++) begin
         drive(0, 1, 0, 0, '0, 1);
         chk("mrst_ov", t_ov, 0);
         chk("mrst_occ", t_occ, 0);
         if (k == 0) chk("mrst_od", t_od, 0);
         tick();
      end

      // DEPTH=0 vector table
      do_reset(0);
      for (int i = 0; i < 6; i++) begin
         drive(0, tab[i].ce, 0, tab[i].iv, tab[i].id, tab[i].ordy);
         chk("d0_rdy", t_rdy, tab[i].e_rdy);
         chk("d0_ov", t_ov, tab[i].e_ov);
         if (tab[i].c_od) chk("d0_od", t_od, tab[i].id);
         tick();
      end
      drive(0, 1, 1, 1, 18'h2BEEF, 1);
      chk("d0_flush_ov", t_ov, 1);
      tick();

      // Randomized against the model
      for (int d = 0; d <= 4; d++) begin
         if (d == 1) continue;
         do_reset(d);
         for (int k = 0; k < 400; k++) begin
            drive($urandom_range(0, 99) == 0,
                  $urandom_range(0, 7) != 0,
                  $urandom_range(0, 39) == 0,
                  $urandom_range(0, 3) != 0,
                  W'($urandom),
                  ((k / 50) % 2 == 1) ? ($urandom_range(0, 3) == 0)
                                      : ($urandom_range(0, 3) != 0));
            tick();
         end
      end

      $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
      $finish;
   end

endmodule
